// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags: requests, data, occupancy
// flags and sticky error status. The FIFO itself takes the slave view.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                    w_en;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    r_en;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    underflow;
  logic                    clr_err;

  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_flags_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         w_ptr;
  logic [AW-1:0]         r_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic full_w;
  logic empty_w;
  logic wr_ok;
  logic rd_ok;

  // Acceptance is judged on pre-edge occupancy, so a full FIFO still
  // accepts a read and an empty one still accepts a write in the same cycle.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign wr_ok   = bus.w_en && !full_w;
  assign rd_ok   = bus.r_en && !empty_w;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[w_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        w_ptr <= w_ptr + AW'(1);
      end
      if (rd_ok) begin
        r_ptr <= r_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A new rejected request outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.w_en && full_w) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bus.r_en && empty_w) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem[r_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q <= '0;
        end else if (rd_ok) begin
          rd_data_q <= mem[r_ptr];
        end
      end

      assign bus.data_out = rd_data_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// scores both against a queue-based model of the FIFO.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_std ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_fw ();

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) dut_std (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_std)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) dut_fw (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_fw)
  );

  typedef struct {
    int            cnt;
    bit            full;
    bit            empty;
    bit            af;
    bit            ae;
    bit            ovf;
    bit            unf;
    logic [DW-1:0] std_data;
    bit            fw_chk;
    logic [DW-1:0] fw_data;
  } exp_t;

  exp_t sb_q[$];

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;
  logic [DW-1:0] m_hold;

  int errors = 0;
  int checks = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.cnt      = mq.size();
    e.full     = (mq.size() == DEPTH);
    e.empty    = (mq.size() == 0);
    e.af       = (mq.size() >= AF);
    e.ae       = (mq.size() <= AE);
    e.ovf      = m_ovf;
    e.unf      = m_unf;
    e.std_data = m_hold;
    e.fw_chk   = (mq.size() != 0);
    e.fw_data  = (mq.size() != 0) ? mq[0] : '0;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    compare("std.count",        32'(bus_std.count),  e.cnt);
    compare("std.full",         32'(bus_std.full),   32'(e.full));
    compare("std.empty",        32'(bus_std.empty),  32'(e.empty));
    compare("std.almost_full",  32'(bus_std.almost_full),  32'(e.af));
    compare("std.almost_empty", 32'(bus_std.almost_empty), 32'(e.ae));
    compare("std.overflow",     32'(bus_std.overflow),  32'(e.ovf));
    compare("std.underflow",    32'(bus_std.underflow), 32'(e.unf));
    compare("std.data_out",     32'(bus_std.data_out),  32'(e.std_data));
    compare("fw.count",         32'(bus_fw.count),  e.cnt);
    compare("fw.full",          32'(bus_fw.full),   32'(e.full));
    compare("fw.empty",         32'(bus_fw.empty),  32'(e.empty));
    compare("fw.almost_full",   32'(bus_fw.almost_full),  32'(e.af));
    compare("fw.almost_empty",  32'(bus_fw.almost_empty), 32'(e.ae));
    compare("fw.overflow",      32'(bus_fw.overflow),  32'(e.ovf));
    compare("fw.underflow",     32'(bus_fw.underflow), 32'(e.unf));
    if (e.fw_chk) begin
      compare("fw.data_out", 32'(bus_fw.data_out), 32'(e.fw_data));
    end
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      checkOutput(sb_q.pop_front());
    end
  end

  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bus_std.w_en = w;  bus_std.data_in = d;  bus_std.r_en = r;  bus_std.clr_err = c;
    bus_fw.w_en  = w;  bus_fw.data_in  = d;  bus_fw.r_en  = r;  bus_fw.clr_err  = c;
  endtask

  task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_full;
    bit was_empty;
    drive(w, d, r, c);
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (w && was_full) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    if (r && was_empty) m_unf = 1'b1;
    else if (c)         m_unf = 1'b0;
    if (r && !was_empty) m_hold = mq.pop_front();
    if (w && !was_full)  mq.push_back(d);
    sb_q.push_back(make_exp());
    #1;
  endtask

  // Reset is asserted between edges and its effect checked before any clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_hold = '0;
    checkOutput(make_exp());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    do_reset();

    $display("[TB] fill, overflow, drain, underflow");
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] clear racing a new overflow, simultaneous at full/empty");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hAC, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] steady read+write at count 5 across pointer wraps");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h41 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(8'h50 + i), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      int wp;
      int rp;
      wp = ((i / 150) % 2 == 0) ? 75 : 30;
      rp = ((i / 150) % 2 == 0) ? 35 : 75;
      applyStimulus($urandom_range(0, 99) < wp, DW'($urandom),
                    $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 5);
    end

    $display("[TB] reset mid-operation");
    do_reset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    do_reset();
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] fall-through head and pop");
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3D, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds a count output wide enough to reach DEPTH, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer datapath stages in the same clock domain.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of 2, at least 4.
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH-1.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-2; must be < AF_THRESH.
- FWFT, 0, read mode: 0 = registered standard read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (FWFT: pop acknowledge).
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected because the FIFO was full.
- underflow  out  1  sticky: a read was rejected because the FIFO was empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - w_ptr, r_ptr, count and data_out go to 0; overflow and underflow go to 0.
  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Deassertion takes effect at the next rising edge.
- Write acceptance: wr_ok = w_en && !full, evaluated on pre-edge state. On wr_ok: mem[w_ptr] <= data_in; w_ptr increments and wraps DEPTH-1 -> 0.
- Read acceptance: rd_ok = r_en && !empty, evaluated on pre-edge state. On rd_ok: r_ptr increments and wraps.
- Count update:
  - count +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
  - count never exceeds DEPTH and never goes below 0.
- Simultaneous requests:
  - Full with w_en and r_en: read accepted, write rejected (overflow sets); count becomes DEPTH-1.
  - Empty with w_en and r_en: write accepted, read rejected (underflow sets); count becomes 1.
  - Otherwise both are accepted, count is unchanged, and pointers advance.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count. Each updates in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - data_out is registered. On rd_ok it loads mem[r_ptr] at that edge (1-cycle read latency); otherwise it holds its value.
  - A word written at edge N is readable with r_en in cycle N+1; its data appears after edge N+1.
- FWFT mode (FWFT=1):
  - data_out = mem[r_ptr] combinationally and is valid whenever empty=0. r_en pops the head.
  - A word written at edge N appears on data_out with empty=0 in cycle N+1.
  - While empty=1, data_out is don't-care; the bench must not check it.
- Errors:
  - overflow sets on w_en && full; underflow sets on r_en && empty.
  - Both hold until clr_err or reset.
  - If clr_err coincides with a new error event, the flag is set (the event wins).
  - Rejected operations change no pointer, count or memory.
- Ordering: strict first-in first-out across any number of pointer wraps.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, data_out=0.
- Fill/drain, default params, FWFT=0:
  - Write 0x01..0x10 on 16 consecutive cycles -> full=1, count=16.
  - almost_full rises the cycle after the 12th write.
  - Then read 16 times -> data_out sequence 0x01..0x10, each one cycle after its read; empty=1 at end.
- Overflow/underflow:
  - On a full FIFO, w_en with 0xAA -> overflow=1, count stays 16, and 0xAA is never read out.
  - On an empty FIFO, r_en -> underflow=1.
  - clr_err pulse -> both flags 0.
  - clr_err in the same cycle as a new rejected write -> overflow=1.
- Simultaneous: with count=5, w_en=r_en=1 for 20 cycles with incrementing data -> count stays 5, data order preserved, pointers wrap without corruption.
  - At full, w_en=r_en=1 -> count=15, overflow=1.
  - At empty, w_en=r_en=1 -> count=1, underflow=1.
- FWFT=1: write 0x3C at edge N -> in cycle N+1, empty=0 and data_out=0x3C with no r_en.
  - Write 0x3D next, then r_en for one cycle -> data_out=0x3D in the following cycle.
- Reset mid-operation: with count=9, pulse rst_n low between edges -> count=0 and empty=1 immediately.
  - Subsequent write 0x55 then read -> 0x55 returned; no stale data appears.
